// File: rtl/quark_pkg.sv
// quark_pkg: shared fetch-sequencer state encoding and constants
package quark_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} tf_state_t;
  localparam logic [3:0] LEN1 = 4'b0001;
  localparam logic [3:0] LEN2 = 4'b0010;
  localparam logic [3:0] LEN4 = 4'b0100;
  localparam logic [3:0] LEN8 = 4'b1000;
  localparam logic [7:0] ERR_MAX = 8'd255;
endpackage

// File: rtl/tail_fetch_if.sv
// tail_fetch_if: nibble input link and assembled-instruction output link
interface tail_fetch_if #(parameter int MAX_LEN = 8);
  logic [3:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [4*MAX_LEN-1:0] out_word;
  logic [3:0] out_len;
  logic out_illegal;
  logic out_valid;
  logic out_ready;
  modport slave (input in_data, in_valid, out_ready,
                 output in_ready, out_word, out_len, out_illegal, out_valid);
  modport master (output in_data, in_valid, out_ready,
                  input in_ready, out_word, out_len, out_illegal, out_valid);
endinterface

// File: rtl/tail_length.sv
// tail_length: one-hot instruction length from the head nibble, 0 when illegal
module tail_length
  import quark_pkg::*;
(
  input  logic [3:0] head_i,
  output logic [3:0] len_o
);
  always_comb
    len_o = head_i == 4'h1 ? LEN2 :
            head_i == 4'h2 ? LEN4 :
            head_i == 4'h3 ? LEN8 :
            head_i inside {4'h0, 4'h4, 4'h8, 4'h9, 4'hC, 4'hD} ? LEN1 : 4'b0000;
endmodule

// File: rtl/tail_fetch.sv
// tail_fetch: collects variable-length instructions nibble by nibble and presents them to decode
module tail_fetch
  import quark_pkg::*;
#(
  parameter int MAX_LEN = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  tail_fetch_if.slave  bus,
  output logic [7:0]   err_count
);
  localparam int W = 4*MAX_LEN;
  tf_state_t state_q, state_d;
  logic [2:0] idx_q, idx_d, remain_q, remain_d;
  logic [W-1:0] word_q, word_d;
  logic [3:0] len_q, len_d, head_len;
  logic ill_q, ill_d, in_fire, illegal;
  logic [7:0] err_q, err_d;
  tail_length u_len (.head_i(bus.in_data), .len_o(head_len));
  // one-hot length value equals the nibble count, so it compares directly against MAX_LEN
  assign illegal = head_len == 4'b0000 || int'(head_len) > MAX_LEN;
  assign in_fire = bus.in_valid && bus.in_ready;
  assign bus.in_ready = state_q != HOLD;
  assign bus.out_valid = state_q == HOLD;
  assign bus.out_word = word_q;
  assign bus.out_len = len_q;
  assign bus.out_illegal = ill_q;
  assign err_count = err_q;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    remain_d = remain_q;
    word_d = word_q;
    len_d = len_q;
    ill_d = ill_q;
    err_d = err_q;
    if (flush) begin
      state_d = IDLE;
      idx_d = '0;
      remain_d = '0;
      word_d = '0;
      len_d = '0;
      ill_d = 1'b0;
    end else if (state_q == IDLE) begin
      if (in_fire) begin
        word_d = W'(bus.in_data);
        ill_d = illegal;
        len_d = illegal ? 4'b0000 : head_len;
        if (illegal || head_len == LEN1) begin
          state_d = HOLD;
          err_d = illegal && err_q != ERR_MAX ? err_q + 8'd1 : err_q;
        end else begin
          state_d = COLLECT;
          idx_d = 3'd1;
          remain_d = 3'(head_len - 4'd1);
        end
      end
    end else if (state_q == COLLECT) begin
      if (in_fire) begin
        for (int k = 0; k < MAX_LEN; k++)
          if (idx_q == 3'(k)) word_d[4*k +: 4] = bus.in_data;
        idx_d = idx_q + 3'd1;
        remain_d = remain_q - 3'd1;
        state_d = remain_q == 3'd1 ? HOLD : COLLECT;
      end
    end else if (bus.out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      remain_q <= '0;
      word_q <= '0;
      len_q <= '0;
      ill_q <= 1'b0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      remain_q <= remain_d;
      word_q <= word_d;
      len_q <= len_d;
      ill_q <= ill_d;
      err_q <= err_d;
    end
endmodule

// File: tb/tb_tail_fetch.sv
// tb_tail_fetch: directed checks of tail_fetch at MAX_LEN 8 and 4
module tb_tail_fetch;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;
  logic [7:0] err_a, err_b;
  int pass_cnt = 0;
  int total = 0;
  tail_fetch_if #(8) ifa ();
  tail_fetch_if #(4) ifb ();
  tail_fetch #(.MAX_LEN(8)) dut (.clk(clk), .reset_n(reset_n), .flush(flush), .bus(ifa), .err_count(err_a));
  tail_fetch #(.MAX_LEN(4)) dut4 (.clk(clk), .reset_n(reset_n), .flush(1'b0), .bus(ifb), .err_count(err_b));
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d);
    ifa.in_valid = 1'b1;
    ifa.in_data = d;
    step();
    ifa.in_valid = 1'b0;
  endtask

  task automatic send4(input logic [3:0] d);
    ifb.in_valid = 1'b1;
    ifb.in_data = d;
    step();
    ifb.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (ifa.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", ifa.in_ready); else pass_cnt++;
    total++; if (ifa.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", ifa.out_valid); else pass_cnt++;
    total++; if (ifa.out_word !== 32'h0) $display("FAIL reset_word got %h exp 0", ifa.out_word); else pass_cnt++;
    total++; if (ifa.out_len !== 4'b0000) $display("FAIL reset_len got %b exp 0000", ifa.out_len); else pass_cnt++;
    total++; if (ifa.out_illegal !== 1'b0) $display("FAIL reset_illegal got %b exp 0", ifa.out_illegal); else pass_cnt++;
    total++; if (err_a !== 8'd0) $display("FAIL reset_err got %0d exp 0", err_a); else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_len1();
    ifa.out_ready = 1'b1;
    send(4'h0);
    total++; if (ifa.out_valid !== 1'b1) $display("FAIL len1_valid got %b exp 1", ifa.out_valid); else pass_cnt++;
    total++; if (ifa.out_word !== 32'h0) $display("FAIL len1_word got %h exp 0", ifa.out_word); else pass_cnt++;
    total++; if (ifa.out_len !== 4'b0001) $display("FAIL len1_len got %b exp 0001", ifa.out_len); else pass_cnt++;
    total++; if (ifa.out_illegal !== 1'b0) $display("FAIL len1_illegal got %b exp 0", ifa.out_illegal); else pass_cnt++;
    step();
    total++; if (ifa.out_valid !== 1'b0) $display("FAIL len1_release got %b exp 0", ifa.out_valid); else pass_cnt++;
  endtask

  task automatic test_len2();
    send(4'h1);
    total++; if (ifa.out_valid !== 1'b0) $display("FAIL len2_early got %b exp 0", ifa.out_valid); else pass_cnt++;
    send(4'hA);
    total++; if (ifa.out_valid !== 1'b1) $display("FAIL len2_valid got %b exp 1", ifa.out_valid); else pass_cnt++;
    total++; if (ifa.out_word !== 32'h000000A1) $display("FAIL len2_word got %h exp 000000a1", ifa.out_word); else pass_cnt++;
    total++; if (ifa.out_len !== 4'b0010) $display("FAIL len2_len got %b exp 0010", ifa.out_len); else pass_cnt++;
    step();
  endtask

  task automatic test_len8();
    logic [3:0] nib [8] = '{4'h3, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
    for (int i = 0; i < 7; i++) send(nib[i]);
    total++; if (ifa.out_valid !== 1'b0) $display("FAIL len8_early got %b exp 0", ifa.out_valid); else pass_cnt++;
    send(nib[7]);
    total++; if (ifa.out_valid !== 1'b1) $display("FAIL len8_valid got %b exp 1", ifa.out_valid); else pass_cnt++;
    total++; if (ifa.out_word !== 32'h76543213) $display("FAIL len8_word got %h exp 76543213", ifa.out_word); else pass_cnt++;
    total++; if (ifa.out_len !== 4'b1000) $display("FAIL len8_len got %b exp 1000", ifa.out_len); else pass_cnt++;
    step();
  endtask

  task automatic test_illegal();
    send(4'h5);
    total++; if (ifa.out_illegal !== 1'b1) $display("FAIL ill_flag got %b exp 1", ifa.out_illegal); else pass_cnt++;
    total++; if (ifa.out_len !== 4'b0000) $display("FAIL ill_len got %b exp 0000", ifa.out_len); else pass_cnt++;
    total++; if (ifa.out_word !== 32'h00000005) $display("FAIL ill_word got %h exp 00000005", ifa.out_word); else pass_cnt++;
    total++; if (err_a !== 8'd1) $display("FAIL ill_err got %0d exp 1", err_a); else pass_cnt++;
    step();
    for (int i = 0; i < 300; i++) begin
      send(4'hE);
      step();
    end
    total++; if (err_a !== 8'd255) $display("FAIL ill_saturate got %0d exp 255", err_a); else pass_cnt++;
  endtask

  task automatic test_stall();
    ifa.out_ready = 1'b0;
    send(4'h2); send(4'h1); send(4'h2); send(4'h3);
    ifa.in_valid = 1'b1;
    ifa.in_data = 4'h9;
    for (int i = 0; i < 3; i++) begin
      total++; if (ifa.out_valid !== 1'b1) $display("FAIL stall_valid%0d got %b exp 1", i, ifa.out_valid); else pass_cnt++;
      total++; if (ifa.out_word !== 32'h00003212) $display("FAIL stall_word%0d got %h exp 00003212", i, ifa.out_word); else pass_cnt++;
      total++; if (ifa.out_len !== 4'b0100) $display("FAIL stall_len%0d got %b exp 0100", i, ifa.out_len); else pass_cnt++;
      total++; if (ifa.in_ready !== 1'b0) $display("FAIL stall_in_ready%0d got %b exp 0", i, ifa.in_ready); else pass_cnt++;
      step();
    end
    ifa.in_valid = 1'b0;
    ifa.out_ready = 1'b1;
    step();
    total++; if (ifa.out_valid !== 1'b0) $display("FAIL stall_release got %b exp 0", ifa.out_valid); else pass_cnt++;
    total++; if (ifa.in_ready !== 1'b1) $display("FAIL stall_idle got %b exp 1", ifa.in_ready); else pass_cnt++;
  endtask

  task automatic test_flush();
    send(4'h3); send(4'h1); send(4'h2);
    flush = 1'b1;
    ifa.in_valid = 1'b1;
    ifa.in_data = 4'h9;
    step();
    flush = 1'b0;
    ifa.in_valid = 1'b0;
    total++; if (ifa.out_valid !== 1'b0) $display("FAIL flush_valid got %b exp 0", ifa.out_valid); else pass_cnt++;
    total++; if (ifa.in_ready !== 1'b1) $display("FAIL flush_idle got %b exp 1", ifa.in_ready); else pass_cnt++;
    total++; if (err_a !== 8'd255) $display("FAIL flush_err got %0d exp 255", err_a); else pass_cnt++;
    send(4'h1); send(4'hB);
    total++; if (ifa.out_valid !== 1'b1) $display("FAIL flush_next_valid got %b exp 1", ifa.out_valid); else pass_cnt++;
    total++; if (ifa.out_word !== 32'h000000B1) $display("FAIL flush_next_word got %h exp 000000b1", ifa.out_word); else pass_cnt++;
    step();
  endtask

  task automatic test_async_reset();
    send(4'h3); send(4'h4);
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (ifa.in_ready !== 1'b1) $display("FAIL areset_in_ready got %b exp 1", ifa.in_ready); else pass_cnt++;
    total++; if (ifa.out_word !== 32'h0) $display("FAIL areset_word got %h exp 0", ifa.out_word); else pass_cnt++;
    total++; if (ifa.out_valid !== 1'b0) $display("FAIL areset_valid got %b exp 0", ifa.out_valid); else pass_cnt++;
    total++; if (err_a !== 8'd0) $display("FAIL areset_err got %0d exp 0", err_a); else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    send(4'h0);
    total++; if (ifa.out_word !== 32'h0 || ifa.out_len !== 4'b0001) $display("FAIL areset_after got %h/%b exp 0/0001", ifa.out_word, ifa.out_len); else pass_cnt++;
    step();
  endtask

  task automatic test_maxlen4();
    ifb.out_ready = 1'b1;
    send4(4'h3);
    total++; if (ifb.out_illegal !== 1'b1) $display("FAIL m4_illegal got %b exp 1", ifb.out_illegal); else pass_cnt++;
    total++; if (ifb.out_len !== 4'b0000) $display("FAIL m4_len got %b exp 0000", ifb.out_len); else pass_cnt++;
    total++; if (ifb.out_word !== 16'h0003) $display("FAIL m4_word got %h exp 0003", ifb.out_word); else pass_cnt++;
    total++; if (err_b !== 8'd1) $display("FAIL m4_err got %0d exp 1", err_b); else pass_cnt++;
    step();
    send4(4'h2); send4(4'h5); send4(4'h6); send4(4'h7);
    total++; if (ifb.out_word !== 16'h7652 || ifb.out_len !== 4'b0100) $display("FAIL m4_len4 got %h/%b exp 7652/0100", ifb.out_word, ifb.out_len); else pass_cnt++;
    total++; if (ifb.out_illegal !== 1'b0) $display("FAIL m4_len4_ill got %b exp 0", ifb.out_illegal); else pass_cnt++;
    step();
  endtask

  initial begin
    ifa.in_valid = 1'b0; ifa.in_data = 4'h0; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_data = 4'h0; ifb.out_ready = 1'b0;
    test_reset();
    test_len1();
    test_len2();
    test_len8();
    test_illegal();
    test_stall();
    test_flush();
    test_async_reset();
    test_maxlen4();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/tail_fetch.md
# tail_fetch

Instruction-fetch sequencer for the variable-length instruction stream. It accepts one nibble per cycle over a valid/ready link and decodes the head nibble's length with `tail_length`. It then collects the remaining nibbles of the instruction and presents the assembled word, its one-hot length and an illegal flag to the decode stage over a second valid/ready link. It sits between the fetch buffer and the instruction decoder.

## Interface
- `MAX_LEN`, default 8: largest accepted instruction length in nibbles; legal values 1, 2, 4, 8. Heads decoding longer than `MAX_LEN` are treated as illegal.
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `flush`  in  1  synchronous abort, highest priority.
- `in_data`  in  4  stream nibble.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  block accepts `in_data` this cycle.
- `out_word`  out  4*MAX_LEN  assembled instruction; head nibble at [3:0], nibble k at [4k+3:4k], unused upper bits zero.
- `out_len`  out  4  one-hot length (0001=1, 0010=2, 0100=4, 1000=8 nibbles); 0000 when illegal.
- `out_illegal`  out  1  head decoded to length 0 or to a length greater than `MAX_LEN`.
- `out_valid`  out  1  output fields valid.
- `out_ready`  in  1  decoder consumes the output.
- `err_count`  out  8  count of illegal heads, saturating at 255.

## Operation
- Handshake: transfer on a link when valid && ready in the same cycle. `out_*` fields are held stable while `out_valid && !out_ready`.
- Length decode: head length = `tail_length(in_data)`. Decode table:
  - 1 nibble: heads 0x0, 0x4, 0x8, 0x9, 0xC, 0xD.
  - 2 nibbles: head 0x1.
  - 4 nibbles: head 0x2.
  - 8 nibbles: head 0x3.
  - Illegal (decode 0): heads 0x5, 0x6, 0x7, 0xA, 0xB, 0xE, 0xF.
- State machine with states IDLE, COLLECT and HOLD:
  - IDLE: `in_ready`=1.
    - On a head transfer: clear the word and store the head at [3:0].
    - If the length is 1 or the head is illegal: go to HOLD.
    - Otherwise: load `remain` = length−1 and go to COLLECT.
  - COLLECT: `in_ready`=1.
    - Each transfer writes `in_data` at nibble index `idx` (starting at 1), increments `idx` and decrements `remain`.
    - When the transfer with `remain`==1 completes: go to HOLD.
  - HOLD: `in_ready`=0, `out_valid`=1.
    - On an output transfer: go to IDLE.
- Illegal head: entering HOLD with an illegal head sets `out_illegal`=1 and `out_len`=0000 with `out_word`=head, and increments `err_count` (saturating).
- `flush` (registered effect, overrides every other event in that cycle):
  - Next state is IDLE; any partial or held word is dropped, so `out_valid`=0 the next cycle.
  - An input transfer in the same cycle is discarded and does not count.
  - `err_count` is unchanged.
- Counter widths: `idx` and `remain` are 3 bits. `remain` never underflows because COLLECT is only entered with length ≥ 2.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `out_word`=0, `out_len`=0000, `out_illegal`=0, `err_count`=0, `idx`=0, `remain`=0.
- Latency: `out_valid` rises in the cycle after the transfer of the last nibble of the instruction.
- Throughput: an N-nibble instruction with no stalls occupies N+1 cycles (N accepts plus 1 HOLD cycle). There is no input accept during HOLD.
- `in_ready` is a function of state only; there is no combinational path from `out_ready` or `in_valid` to it.
- `in_valid` low during COLLECT stalls collection indefinitely; no timeout.
- Reset asserted mid-instruction immediately returns all outputs to their reset values, asynchronously.

## Structure
- Shared package `quark_pkg` holds:
  - state enum `tf_state_t` (IDLE, COLLECT, HOLD);
  - one-hot length constants `LEN1`, `LEN2`, `LEN4`, `LEN8`;
  - `ERR_MAX` = 255.
- One sub-module: the existing `tail_length` decoder, instantiated once on `in_data`.
- Everything else is flat: state register, `idx`/`remain` counters, word register, error counter.

## Test plan
- Head 0x0 then `out_ready`=1 → one cycle later `out_valid`=1, `out_word`=0x00000000, `out_len`=0001, `out_illegal`=0.
- Nibbles 0x1, 0xA → `out_word`=0x000000A1, `out_len`=0010. Nibbles 0x3, 1, 2, 3, 4, 5, 6, 7 → `out_word`=0x76543213, `out_len`=1000, `out_valid` the cycle after nibble 7 transfers.
- Head 0x5 → `out_illegal`=1, `out_len`=0000, `out_word`=0x00000005, `err_count`=1. Then 300 illegal heads → `err_count` saturates at 255.
- Complete 0x2 instruction with `out_ready` low for 3 cycles → `out_*` held stable, `in_ready`=0 throughout, released and IDLE on the cycle `out_ready` rises.
- Head 0x3 plus 2 nibbles, then `flush` → next cycle IDLE, `out_valid`=0. Next head 0x1, 0xB yields 0x000000B1 with no stale nibbles.
- Pulse `reset_n` low mid-COLLECT → all outputs at reset values immediately. `MAX_LEN`=4 with head 0x3 → treated as illegal, `err_count` increments.
